// File: rtl/segre_sb_pkg.sv
// Shared sizes and memory-operation type used by the store buffer and its bench.
package segre_sb_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

endpackage

// File: rtl/segre_store_buffer.sv
// Committed-store FIFO with load lookup and a req/ack drain port towards the MMU.
// Macro SB_FORWARD_EN enables exact-match store-to-load forwarding.
module segre_store_buffer
  import segre_sb_pkg::*;
#(
  parameter int SB_ENTRIES      = 4,
  parameter int SB_DRAIN_THRESH = 2
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 alloc_valid_i,
  input  logic [ADDR_SIZE-1:0] alloc_addr_i,
  input  logic [WORD_SIZE-1:0] alloc_data_i,
  input  memop_data_type_e     alloc_type_i,
  input  logic                 lookup_valid_i,
  input  logic [ADDR_SIZE-1:0] lookup_addr_i,
  input  memop_data_type_e     lookup_type_i,
  output logic                 hit_o,
  output logic [WORD_SIZE-1:0] hit_data_o,
  output logic [ADDR_SIZE-1:0] hit_addr_o,
  output logic                 conflict_o,
  input  logic                 mem_idle_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 drain_req_o,
  output logic [ADDR_SIZE-1:0] drain_addr_o,
  output logic [WORD_SIZE-1:0] drain_data_o,
  output memop_data_type_e     drain_type_o,
  input  logic                 drain_ack_i,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int IDX_W = $clog2(SB_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_REQ  = 1'b1
  } drain_state_e;

  logic [ADDR_SIZE-1:0] addr_q [SB_ENTRIES];
  logic [WORD_SIZE-1:0] data_q [SB_ENTRIES];
  memop_data_type_e     type_q [SB_ENTRIES];
  logic [SB_ENTRIES-1:0] valid_q;

  logic [IDX_W-1:0]     head_q, tail_q, head_nxt_s;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 flushing_q, flush_done_q;

  drain_state_e         state_q;
  logic                 drain_req_q;
  logic [ADDR_SIZE-1:0] drain_addr_q;
  logic [WORD_SIZE-1:0] drain_data_q;
  memop_data_type_e     drain_type_q;

  logic pop_s, alloc_s, trig_s, start_s, cont_s, alloc_conf_s;

  assign full_o       = (count_q == CNT_W'(SB_ENTRIES));
  assign empty_o      = (count_q == '0);
  assign flush_done_o = flush_done_q;
  assign drain_req_o  = drain_req_q;
  assign drain_addr_o = drain_addr_q;
  assign drain_data_o = drain_data_q;
  assign drain_type_o = drain_type_q;

  // A pop frees a slot, so a push into a full buffer is accepted in the same cycle.
  assign pop_s      = drain_req_q & drain_ack_i;
  assign alloc_s    = alloc_valid_i & (~full_o | pop_s);
  assign head_nxt_s = head_q + IDX_W'(1);
  assign trig_s     = mem_idle_i | flushing_q | flush_i;
  assign start_s    = ~empty_o & ((count_q >= CNT_W'(SB_DRAIN_THRESH)) | trig_s);
  assign cont_s     = (count_q > CNT_W'(1)) & ((count_d >= CNT_W'(SB_DRAIN_THRESH)) | trig_s);
  assign alloc_conf_s = alloc_valid_i &
                        (alloc_addr_i[ADDR_SIZE-1:2] == lookup_addr_i[ADDR_SIZE-1:2]);

  always_comb begin
    count_d = count_q;
    case ({alloc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and flush tracking.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flushing_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      if (alloc_s) tail_q <= tail_q + IDX_W'(1);
      if (pop_s)   head_q <= head_nxt_s;
      count_q      <= count_d;
      flushing_q   <= (flushing_q | flush_i) & (count_d != '0);
      flush_done_q <= (flushing_q | flush_i) & (count_d == '0);
    end
  end

  // Entry storage; an alloc into the slot being popped wins over the invalidate.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      for (int i = 0; i < SB_ENTRIES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        type_q[i] <= BYTE;
      end
    end else begin
      if (pop_s) valid_q[head_q] <= 1'b0;
      if (alloc_s) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= alloc_addr_i;
        data_q[tail_q]  <= alloc_data_i;
        type_q[tail_q]  <= alloc_type_i;
      end
    end
  end

  // Drain FSM: drain_* hold a registered copy of the head until it is acked.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= DR_IDLE;
      drain_req_q  <= 1'b0;
      drain_addr_q <= '0;
      drain_data_q <= '0;
      drain_type_q <= BYTE;
    end else begin
      case (state_q)
        DR_IDLE: begin
          if (start_s) begin
            state_q      <= DR_REQ;
            drain_req_q  <= 1'b1;
            drain_addr_q <= addr_q[head_q];
            drain_data_q <= data_q[head_q];
            drain_type_q <= type_q[head_q];
          end
        end
        DR_REQ: begin
          if (drain_ack_i) begin
            if (cont_s) begin
              drain_addr_q <= addr_q[head_nxt_s];
              drain_data_q <= data_q[head_nxt_s];
              drain_type_q <= type_q[head_nxt_s];
            end else begin
              state_q      <= DR_IDLE;
              drain_req_q  <= 1'b0;
              drain_addr_q <= '0;
              drain_data_q <= '0;
              drain_type_q <= BYTE;
            end
          end
        end
        default: begin
          state_q     <= DR_IDLE;
          drain_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SB_FORWARD_EN
  logic             match_s;
  logic             exact_s;
  logic [IDX_W-1:0] match_idx_s;

  // Walk oldest to youngest so the youngest word match is the one kept.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = head_q;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      if (valid_q[head_q + IDX_W'(i)] &&
          (addr_q[head_q + IDX_W'(i)][ADDR_SIZE-1:2] == lookup_addr_i[ADDR_SIZE-1:2])) begin
        match_s     = 1'b1;
        match_idx_s = head_q + IDX_W'(i);
      end else begin
        match_s     = match_s;
      end
    end
    exact_s    = match_s && (addr_q[match_idx_s] == lookup_addr_i) &&
                 (type_q[match_idx_s] == lookup_type_i);
    hit_o      = lookup_valid_i & exact_s & ~alloc_conf_s;
    conflict_o = lookup_valid_i & ((match_s & ~exact_s) | alloc_conf_s);
    hit_data_o = hit_o ? data_q[match_idx_s] : '0;
    hit_addr_o = hit_o ? addr_q[match_idx_s] : '0;
  end
`else
  logic match_s;
  logic lookup_unused_s;

  assign lookup_unused_s = ^{lookup_type_i, lookup_addr_i[1:0]};

  // Without forwarding any word overlap simply stalls the load.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      if (valid_q[i] && (addr_q[i][ADDR_SIZE-1:2] == lookup_addr_i[ADDR_SIZE-1:2])) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
    hit_o      = 1'b0;
    hit_data_o = '0;
    hit_addr_o = '0;
    conflict_o = lookup_valid_i & (match_s | alloc_conf_s);
  end
`endif

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed bench for segre_store_buffer; expectations follow SB_FORWARD_EN when defined.
module tb_segre_store_buffer;
  import segre_sb_pkg::*;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rsn = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [31:0]      alloc_addr = 32'h0;
  logic [31:0]      alloc_data = 32'h0;
  memop_data_type_e alloc_type = WORD;
  logic             lookup_valid = 1'b0;
  logic [31:0]      lookup_addr = 32'h0;
  memop_data_type_e lookup_type = WORD;
  logic             mem_idle = 1'b0;
  logic             flush = 1'b0;
  logic             drain_ack = 1'b0;
  logic             hit, conflict, flush_done, drain_req, full, empty;
  logic [31:0]      hit_data, hit_addr, drain_addr, drain_data;
  memop_data_type_e drain_type;

  int checks = 0;
  int failures = 0;

  segre_store_buffer #(.SB_ENTRIES(4), .SB_DRAIN_THRESH(2)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
    .alloc_data_i(alloc_data), .alloc_type_i(alloc_type),
    .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr), .lookup_type_i(lookup_type),
    .hit_o(hit), .hit_data_o(hit_data), .hit_addr_o(hit_addr), .conflict_o(conflict),
    .mem_idle_i(mem_idle), .flush_i(flush), .flush_done_o(flush_done),
    .drain_req_o(drain_req), .drain_addr_o(drain_addr), .drain_data_o(drain_data),
    .drain_type_o(drain_type), .drain_ack_i(drain_ack),
    .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rsn = 1'b0;
    alloc_valid = 1'b0; lookup_valid = 1'b0; mem_idle = 1'b0; flush = 1'b0; drain_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    alloc_valid = 1'b1; alloc_addr = a; alloc_data = d; alloc_type = t;
    @(negedge clk);
    alloc_valid = 1'b0;
  endtask

  task automatic probe(input logic [31:0] a, input memop_data_type_e t);
    lookup_valid = 1'b1; lookup_addr = a; lookup_type = t;
    #1;
  endtask

  task automatic test_reset();
    rsn = 1'b0;
    #1;
    checks++; if (drain_req !== 1'b0) begin failures++; $display("FAIL rst_drain_req: got %b expected 0", drain_req); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if ({hit, conflict, flush_done} !== 3'b000) begin failures++; $display("FAIL rst_hit_conf_done: got %b expected 000", {hit, conflict, flush_done}); end
    checks++; if (drain_addr !== 32'h0 || drain_data !== 32'h0 || hit_data !== 32'h0) begin failures++; $display("FAIL rst_data: got %h/%h/%h expected 0", drain_addr, drain_data, hit_data); end
    do_reset();
  endtask

  task automatic test_forward();
    do_reset();
    alloc(32'h100, 32'hDEADBEEF, WORD);
    probe(32'h100, WORD);
    checks++; if (hit !== FWD) begin failures++; $display("FAIL fwd_hit: got %b expected %b", hit, FWD); end
    checks++; if (hit_data !== (FWD ? 32'hDEADBEEF : 32'h0)) begin failures++; $display("FAIL fwd_data: got %h expected %h", hit_data, FWD ? 32'hDEADBEEF : 32'h0); end
    checks++; if (conflict !== !FWD) begin failures++; $display("FAIL fwd_conflict: got %b expected %b", conflict, !FWD); end
    checks++; if (drain_req !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL fwd_no_drain: got req=%b empty=%b expected 0/0", drain_req, empty); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_partial();
    do_reset();
    alloc(32'h101, 32'hAA, BYTE);
    alloc(32'h200, 32'h11, WORD);
    probe(32'h100, HALF);
    checks++; if ({hit, conflict} !== 2'b01) begin failures++; $display("FAIL partial_half: got hit/conf=%b expected 01", {hit, conflict}); end
    probe(32'h101, BYTE);
    checks++; if (hit !== FWD || conflict !== !FWD) begin failures++; $display("FAIL partial_byte: got hit/conf=%b%b expected %b%b", hit, conflict, FWD, !FWD); end
    checks++; if (hit_data !== (FWD ? 32'hAA : 32'h0) || hit_addr !== (FWD ? 32'h101 : 32'h0)) begin failures++; $display("FAIL partial_byte_data: got %h@%h", hit_data, hit_addr); end
    probe(32'h204, WORD);
    checks++; if ({hit, conflict} !== 2'b00) begin failures++; $display("FAIL partial_nomatch: got hit/conf=%b expected 00", {hit, conflict}); end
    lookup_valid = 1'b0;
    @(negedge clk);
    checks++; if (drain_req !== 1'b1 || drain_addr !== 32'h101 || drain_data !== 32'hAA || drain_type !== BYTE) begin failures++; $display("FAIL thresh_drain: got req=%b %h/%h/%0d expected 1 101/aa/0", drain_req, drain_addr, drain_data, drain_type); end
  endtask

  task automatic test_youngest();
    do_reset();
    alloc(32'h100, 32'h1, WORD);
    alloc(32'h100, 32'h2, WORD);
    probe(32'h100, WORD);
    checks++; if (hit !== FWD || hit_data !== (FWD ? 32'h2 : 32'h0)) begin failures++; $display("FAIL youngest: got hit=%b data=%h expected %b/%h", hit, hit_data, FWD, FWD ? 32'h2 : 32'h0); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    alloc(32'h10, 32'h1, WORD);
    alloc(32'h20, 32'h2, WORD);
    alloc(32'h30, 32'h3, WORD);
    alloc(32'h40, 32'h4, WORD);
    checks++; if (full !== 1'b1 || drain_req !== 1'b1 || drain_addr !== 32'h10 || drain_data !== 32'h1) begin failures++; $display("FAIL full_hold: got full=%b req=%b %h/%h", full, drain_req, drain_addr, drain_data); end
    alloc(32'h50, 32'h5, WORD);
    checks++; if (full !== 1'b1 || drain_addr !== 32'h10) begin failures++; $display("FAIL full_drop: got full=%b addr=%h expected 1/10", full, drain_addr); end
    probe(32'h50, WORD);
    checks++; if ({hit, conflict} !== 2'b00) begin failures++; $display("FAIL dropped_lookup: got hit/conf=%b expected 00", {hit, conflict}); end
    lookup_valid = 1'b0;
    drain_ack = 1'b1;
    alloc(32'h60, 32'h6, WORD);
    checks++; if (full !== 1'b1 || drain_addr !== 32'h20 || drain_data !== 32'h2) begin failures++; $display("FAIL alloc_pop: got full=%b %h/%h expected 1 20/2", full, drain_addr, drain_data); end
    mem_idle = 1'b1;
    @(negedge clk);
    checks++; if (drain_addr !== 32'h30) begin failures++; $display("FAIL order_30: got %h expected 30", drain_addr); end
    @(negedge clk);
    checks++; if (drain_addr !== 32'h40) begin failures++; $display("FAIL order_40: got %h expected 40", drain_addr); end
    @(negedge clk);
    checks++; if (drain_addr !== 32'h60 || drain_data !== 32'h6) begin failures++; $display("FAIL wrap_entry: got %h/%h expected 60/6", drain_addr, drain_data); end
    @(negedge clk);
    drain_ack = 1'b0;
    checks++; if (empty !== 1'b1 || drain_req !== 1'b0) begin failures++; $display("FAIL drained: got empty=%b req=%b expected 1/0", empty, drain_req); end
    mem_idle = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] seen [3];
    int n = 0;
    int done_cnt = 0;
    bit phase = 1'b1;
    do_reset();
    alloc(32'hA0, 32'hA, WORD);
    alloc(32'hB0, 32'hB, WORD);
    alloc(32'hC0, 32'hC, WORD);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (flush_done) done_cnt++;
      if (drain_req && phase) begin
        if (n < 3) seen[n] = drain_addr;
        n++;
        drain_ack = 1'b1;
      end else begin
        drain_ack = 1'b0;
      end
      phase = ~phase;
      @(negedge clk);
    end
    drain_ack = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL flush_count: got %0d expected 3", n); end
    checks++; if (seen[0] !== 32'hA0 || seen[1] !== 32'hB0 || seen[2] !== 32'hC0) begin failures++; $display("FAIL flush_order: got %h %h %h expected a0 b0 c0", seen[0], seen[1], seen[2]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL flush_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (empty !== 1'b1 || drain_req !== 1'b0) begin failures++; $display("FAIL flush_empty: got empty=%b req=%b", empty, drain_req); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL flush_empty_done: got %b expected 1", flush_done); end
    @(negedge clk);
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_done_width: got %b expected 0", flush_done); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 32'h400; alloc_data = 32'h55; alloc_type = WORD;
    probe(32'h402, HALF);
    checks++; if ({hit, conflict} !== 2'b01) begin failures++; $display("FAIL same_cycle_alloc: got hit/conf=%b expected 01", {hit, conflict}); end
    @(negedge clk);
    alloc_valid = 1'b0;
    lookup_valid = 1'b0; lookup_addr = 32'h400; lookup_type = WORD;
    #1;
    checks++; if ({hit, conflict} !== 2'b00) begin failures++; $display("FAIL lookup_invalid: got hit/conf=%b expected 00", {hit, conflict}); end
    probe(32'h400, WORD);
    checks++; if (hit !== FWD || hit_addr !== (FWD ? 32'h400 : 32'h0) || conflict !== !FWD) begin failures++; $display("FAIL bypass_next: got hit=%b addr=%h conf=%b", hit, hit_addr, conflict); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    alloc(32'h300, 32'h33, WORD);
    alloc(32'h308, 32'h44, WORD);
    @(negedge clk);
    checks++; if (drain_req !== 1'b1) begin failures++; $display("FAIL pre_reset_req: got %b expected 1", drain_req); end
    rsn = 1'b0;
    #1;
    checks++; if (drain_req !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_reset_flags: got req=%b empty=%b full=%b", drain_req, empty, full); end
    checks++; if (drain_addr !== 32'h0 || drain_data !== 32'h0) begin failures++; $display("FAIL mid_reset_data: got %h/%h expected 0/0", drain_addr, drain_data); end
    @(negedge clk);
    rsn = 1'b1;
    probe(32'h300, WORD);
    checks++; if ({hit, conflict} !== 2'b00) begin failures++; $display("FAIL post_reset_lookup: got hit/conf=%b expected 00", {hit, conflict}); end
    lookup_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_forward();
    test_partial();
    test_youngest();
    test_full();
    test_flush();
    test_bypass();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
